// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer driving one external 4-bit ripple adder.
// Also holds the 4-bit ripple-carry adder that the sequencer is paired with.

module FourBitRippleCarryAdder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c,
    output logic [3:0] S,
    output logic       c4
);
    logic [4:0] carry;

    always_comb begin
        carry[0] = c;
        S        = '0;
        for (int i = 0; i < 4; i++) begin
            S[i]         = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        c4 = carry[4];
    end
endmodule

// state | meaning
// IDLE  | waiting for start; adder inputs held at 0
// RUN   | one nibble per cycle, carry chained through carry_q
// DONE  | result valid, one-cycle done pulse
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [3:0]   add_a,
    output logic [3:0]   add_b,
    output logic         add_c,
    input  logic [3:0]   add_s,
    input  logic         add_c4,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_q, state_d;
    logic [NIBBLES-1:0][3:0]    a_q, a_d;
    logic [NIBBLES-1:0][3:0]    b_q, b_d;
    logic [NIBBLES-1:0][3:0]    sum_q, sum_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic                       carry_q, carry_d;
    logic                       cout_q, cout_d;
    logic                       ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        add_a   = '0;
        add_b   = '0;
        add_c   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = sub ? ~op_b : op_b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy         = 1'b1;
                add_a        = a_q[idx_q];
                add_b        = b_q[idx_q];
                add_c        = carry_q;
                sum_d[idx_q] = add_s;
                carry_d      = add_c4;
                idx_d        = idx_q + IW'(1);
                // Top slice: operand signs agree but result sign differs => overflow
                if (idx_q == IW'(NIBBLES - 1)) begin
                    cout_d  = add_c4;
                    ovf_d   = (a_q[NIBBLES-1][3] == b_q[NIBBLES-1][3]) &&
                              (add_s[3] != a_q[NIBBLES-1][3]);
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops them on done.

module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   add_a, add_b, add_s;
    logic         add_c, add_c4;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t exp_q[$];

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
        .op_a(op_a), .op_b(op_b),
        .add_a(add_a), .add_b(add_b), .add_c(add_c),
        .add_s(add_s), .add_c4(add_c4),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    FourBitRippleCarryAdder u_add (
        .A(add_a), .B(add_b), .c(add_c), .S(add_s), .c4(add_c4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_sum"},  32'(sum),   32'(e.s));
                chk({e.name, "_cout"}, 32'(cout),  32'(e.co));
                chk({e.name, "_ovf"},  32'(ovf),   32'(e.ov));
                chk({e.name, "_lat"},  32'(cyc),   32'(e.done_cyc));
                chk({e.name, "_busy"}, 32'(busy),  32'd1);
            end
        end
    end

    // Called at a negedge; start is sampled at the next rising edge.
    task automatic start_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic c, input logic [W-1:0] es,
                            input logic eco, input logic eov, input bit push);
        exp_t e;
        op_a  = a;
        op_b  = b;
        sub   = s;
        cin   = c;
        start = 1'b1;
        if (push) begin
            e.s = es; e.co = eco; e.ov = eov; e.done_cyc = cyc + N + 1; e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=1 after %0d cycles expected 0", name, n);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum",  32'(sum),  0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ovf",  32'(ovf),  0);
        chk("rst_adder", {23'd0, add_a, add_b, add_c}, 0);
        @(negedge clk);

        start_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1);
        chk("run_busy",  32'(busy),  1);
        chk("run_add_a", 32'(add_a), 32'h4);
        chk("run_add_b", 32'(add_b), 32'h1);
        chk("run_add_c", 32'(add_c), 0);
        wait_idle("add1");
        chk("hold_sum", 32'(sum), 32'h5555);

        start_op("addmax", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        wait_idle("addmax");
        start_op("addcin", 16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 1);
        wait_idle("addcin");

        start_op("sub57", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1);
        chk("sub_add_a", 32'(add_a), 32'h5);
        chk("sub_add_b", 32'(add_b), 32'h8);
        chk("sub_add_c", 32'(add_c), 1);
        wait_idle("sub57");
        start_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1);
        wait_idle("subovf");

        start_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1);
        wait_idle("addovf");
        start_op("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1);
        wait_idle("negovf");

        // start during RUN must be ignored; then back-to-back on first IDLE cycle
        start_op("first", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1);
        start_op("ignored", 16'hAAAA, 16'h5555, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 0);
        wait_idle("first");
        start_op("b2b", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1);
        wait_idle("b2b");

        // reset asserted in the second RUN cycle aborts without done
        start_op("abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_sum",  32'(sum),  0);
        repeat (N + 2) @(negedge clk);
        start_op("fresh", 16'h9999, 16'h6667, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1);
        wait_idle("fresh");
        repeat (3) @(negedge clk);

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
